// File: rtl/seg_pkg.sv
// seg_pkg: font table, blank code and debouncer state type shared by the
// seg_scan_display scanner and its button debouncer.
package seg_pkg;
    localparam logic [6:0] FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    typedef enum logic [2:0] {IDLE, WAIT_PRESS, PRESSED, HELD, WAIT_RELEASE} deb_state_t;
endpackage

// File: rtl/seg_debounce.sv
// seg_debounce: 2-FF synchroniser plus debouncer FSM; emits one press pulse
// per accepted press, however long the button is held.
module seg_debounce
    import seg_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    // the sample that enters a WAIT state is the first of the DEBOUNCE_CYC
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 2);

    logic [1:0] sync_ff;
    logic sync;
    logic [CW-1:0] cnt, cnt_n;
    deb_state_t state, state_n;

    assign sync  = sync_ff[1];
    assign press = state == PRESSED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            state   <= IDLE;
            cnt     <= '0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            state   <= state_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        case (state)
            IDLE:         state_n = sync ? WAIT_PRESS : IDLE;
            WAIT_PRESS: begin
                state_n = !sync ? IDLE : (cnt == LAST) ? PRESSED : WAIT_PRESS;
                cnt_n   = (sync && cnt != LAST) ? cnt + 1'b1 : '0;
            end
            PRESSED:      state_n = HELD;
            HELD:         state_n = sync ? HELD : WAIT_RELEASE;
            WAIT_RELEASE: begin
                state_n = sync ? HELD : (cnt == LAST) ? IDLE : WAIT_RELEASE;
                cnt_n   = (!sync && cnt != LAST) ? cnt + 1'b1 : '0;
            end
            default:      state_n = IDLE;
        endcase
    end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: paged, tear-free multiplexed 7-segment scanner with a
// debounced page button. Define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_W       = 32,
    parameter int SCAN_DIV     = 10000,
    parameter int DEBOUNCE_CYC = 20000,
    localparam int PAGES       = DATA_W / (4 * NUM_DIGITS),
    localparam int PAGE_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  button,
    input  logic                  freeze,
    input  logic [DATA_W-1:0]     data,
    output logic [7:0]            smg,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [PAGE_W-1:0]     page
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = 4 * NUM_DIGITS;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx, idx_n;
    logic [DATA_W-1:0] snap, snap_n;
    logic [PAGE_W-1:0] pend, page_n;
    logic [PW-1:0] pw;
    logic [3:0] nib;
    logic [7:0] smg_n;
    logic [NUM_DIGITS-1:0] sel_n;
    logic tick, last, bnd, dp, blank, press;

    seg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (button),
        .press (press)
    );

    assign tick = cnt == CW'(SCAN_DIV - 1);
    assign last = idx == IW'(NUM_DIGITS - 1);
    assign bnd  = tick && last;

    // outputs are built from the post-tick digit, snapshot and page so sel and smg move together
    always_comb begin
        idx_n  = last ? '0 : idx + 1'b1;
        snap_n = (bnd && !freeze) ? data : snap;
        page_n = bnd ? pend : page;
        pw     = snap_n[int'(page_n) * PW +: PW];
        nib    = pw[4 * int'(idx_n) +: 4];
        dp     = !(PAGES > 1 && int'(page_n) == int'(idx_n));
`ifdef SEG_LEADING_ZERO_BLANK_EN
        blank  = idx_n != '0 && (pw >> (4 * int'(idx_n))) == '0;
`else
        blank  = 1'b0;
`endif
        smg_n  = {blank ? 7'h7F : FONT[nib], dp};
        sel_n  = ~(NUM_DIGITS'(1) << idx_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            idx  <= '0;
            snap <= '0;
            pend <= '0;
            page <= '0;
            sel  <= '1;
            smg  <= SEG_BLANK;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx  <= idx_n;
                snap <= snap_n;
                page <= page_n;
                sel  <= sel_n;
                smg  <= smg_n;
            end
            if (press && PAGES > 1)
                pend <= (pend == PAGE_W'(PAGES - 1)) ? '0 : pend + 1'b1;
        end
    end
endmodule
